// File: rtl/disc_ctrl_pkg.sv
// Shared types and constants for the discriminator pipeline controller:
// state encoding, vector/score widths and the Q8.8 score format.
package disc_ctrl_pkg;

    localparam int Q_FRAC_W = 8;
    localparam int SCORE_W  = 2 * Q_FRAC_W;
    localparam int VEC_LEN  = 256;
    localparam int VEC_W    = VEC_LEN * SCORE_W;

    typedef logic signed [SCORE_W-1:0] q8_8_t;

    localparam q8_8_t Q8_8_ZERO = '0;

    typedef enum logic [2:0] {
        IDLE,
        L1_START,
        L1_WAIT,
        L2_START,
        L2_WAIT,
        L3_START,
        L3_WAIT,
        OUT_HOLD
    } ctrl_state_t;

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage wait watchdog: counts enabled cycles since the last clear and
// flags the final permitted cycle of a stage wait.
module stage_watchdog #(
    parameter int TIMEOUT_CYCLES = 40000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    // Expiry lands on the TIMEOUT_CYCLES-th wait cycle, so the state leaves
    // WAIT exactly TIMEOUT_CYCLES cycles after entering it.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/disc_pipeline_ctrl.sv
// Sequencer for the three-layer discriminator: accepts an input vector,
// starts each layer engine in turn, guards each wait with a watchdog and
// holds the final score until the consumer takes it.
module disc_pipeline_ctrl
    import disc_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 40000,
    parameter int FRAME_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [VEC_W-1:0]       in_data,
    input  logic                   abort,
    output logic [VEC_W-1:0]       l1_in,
    output logic                   l1_start,
    output logic                   l2_start,
    output logic                   l3_start,
    input  logic                   l1_done,
    input  logic                   l2_done,
    input  logic                   l3_done,
    input  logic signed [SCORE_W-1:0] l3_score,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [SCORE_W-1:0] out_score,
    output logic                   out_error,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    ctrl_state_t state, state_nx;

    logic accept;
    logic capture;
    logic time_out;
    logic deliver;
    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    assign wd_clear  = (state == L1_START) || (state == L2_START) || (state == L3_START);
    assign wd_enable = (state == L1_WAIT)  || (state == L2_WAIT)  || (state == L3_WAIT);

    stage_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nx;
            in_ready <= (state_nx == IDLE);
        end
    end

    // Abort outranks everything; within a wait, done outranks expiry.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        capture  = 1'b0;
        time_out = 1'b0;
        deliver  = 1'b0;
        if (abort && (state != IDLE)) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        accept   = 1'b1;
                        state_nx = L1_START;
                    end
                end
                L1_START: state_nx = L1_WAIT;
                L1_WAIT: begin
                    if (l1_done) begin
                        state_nx = L2_START;
                    end else if (wd_expired) begin
                        time_out = 1'b1;
                        state_nx = OUT_HOLD;
                    end
                end
                L2_START: state_nx = L2_WAIT;
                L2_WAIT: begin
                    if (l2_done) begin
                        state_nx = L3_START;
                    end else if (wd_expired) begin
                        time_out = 1'b1;
                        state_nx = OUT_HOLD;
                    end
                end
                L3_START: state_nx = L3_WAIT;
                L3_WAIT: begin
                    if (l3_done) begin
                        capture  = 1'b1;
                        state_nx = OUT_HOLD;
                    end else if (wd_expired) begin
                        time_out = 1'b1;
                        state_nx = OUT_HOLD;
                    end
                end
                OUT_HOLD: begin
                    if (out_ready) begin
                        deliver  = 1'b1;
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l1_in <= '0;
        end else if (accept) begin
            l1_in <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_score <= Q8_8_ZERO;
            out_error <= 1'b0;
        end else if (capture) begin
            out_score <= l3_score;
            out_error <= 1'b0;
        end else if (time_out) begin
            out_score <= Q8_8_ZERO;
            out_error <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count <= '0;
        end else if (deliver) begin
            frame_count <= frame_count + 1'b1;
        end
    end

    // A start pulse is suppressed if abort arrives in its own cycle.
    assign l1_start  = (state == L1_START) && !abort;
    assign l2_start  = (state == L2_START) && !abort;
    assign l3_start  = (state == L3_START) && !abort;
    assign out_valid = (state == OUT_HOLD);
    assign busy      = (state != IDLE);

endmodule

// File: doc/disc_pipeline_ctrl.md
DISC_PIPELINE_CTRL -- requirements
Module: disc_pipeline_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 40000, meaning maximum cycles allowed in any stage wait before error abort.
REQ-002 SHALL have parameter FRAME_CNT_W, default 16, meaning width of completed-frame counter.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input frame offered.
- in_ready  out  1  controller can accept a frame.
- in_data  in  4096  256 x Q8.8 input vector.
- abort  in  1  synchronous abort request.
- l1_in  out  4096  latched input vector driving layer-1 engine.
- l1_start, l2_start, l3_start  out  1 each  single-cycle stage start pulses.
- l1_done, l2_done, l3_done  in  1 each  single-cycle stage completion pulses.
- l3_score  in  16  Q8.8 final-stage result, valid on l3_done.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_score  out  16  Q8.8 discriminator score.
- out_error  out  1  result produced by timeout; score invalid.
- busy  out  1  high in any state other than IDLE.
- frame_count  out  FRAME_CNT_W  completed-frame count.

Function
REQ-004 SHALL implement states IDLE, L1_START, L1_WAIT, L2_START, L2_WAIT, L3_START, L3_WAIT, OUT_HOLD.
REQ-005 in_ready SHALL be registered and high only while in IDLE and not transferring this cycle.
REQ-006 On in_valid && in_ready, SHALL latch in_data into l1_in and move to L1_START; l1_in SHALL hold until the next accept.
REQ-007 In each Lx_START, SHALL assert lx_start for exactly one cycle, clear the watchdog, then move to Lx_WAIT.
REQ-008 In L1_WAIT/L2_WAIT, lx_done SHALL advance to the next Lx_START; in L3_WAIT, l3_done SHALL capture l3_score into out_score, clear out_error, move to OUT_HOLD.
REQ-009 Start pulses SHALL be issued on consecutive-state boundaries only: accept at cycle N gives l1_start at N+1; lx_done at cycle M gives l(x+1)_start at M+1.
REQ-010 Done pulses from a stage other than the one being waited on, or received outside a WAIT state, SHALL be ignored.
REQ-011 Watchdog SHALL count cycles in each WAIT state; when it reaches TIMEOUT_CYCLES without the expected done, SHALL set out_score=0, out_error=1, move to OUT_HOLD.
REQ-012 Done arriving in the same cycle the watchdog expires SHALL take priority (normal completion).
REQ-013 In OUT_HOLD, out_valid SHALL be high and out_score/out_error stable until out_valid && out_ready; then SHALL return to IDLE and increment frame_count, wrapping at 2^FRAME_CNT_W.
REQ-014 abort high in any non-IDLE state SHALL return to IDLE next cycle: no start pulse, out_valid low, frame_count unchanged; abort in IDLE SHALL have no effect.
REQ-015 abort SHALL take priority over done, timeout and out_ready in the same cycle.
REQ-016 out_valid SHALL be low in every state except OUT_HOLD.

Reset
REQ-017 rst SHALL force state IDLE and all outputs to zero (in_ready 0, starts 0, out_valid 0, out_score 0, out_error 0, busy 0, frame_count 0, l1_in 0) asynchronously.
REQ-018 in_ready SHALL rise on the first clock edge after rst deasserts.
REQ-019 rst mid-frame SHALL discard the frame; later done pulses for it are ignored per REQ-010.

Structure
REQ-020 State encoding, vector widths (4096, 16) and the Q8.8 format constant SHALL live in shared package disc_ctrl_pkg.
REQ-021 Watchdog SHALL be sub-module stage_watchdog (clear, enable, expired) parameterised by TIMEOUT_CYCLES.

Verification
REQ-022 Nominal: accept frame at cycle 10, done pulses 5 cycles after each start, l3_score=0x0180 -> l1_start cycle 11, out_valid with out_score=0x0180, out_error=0, frame_count=1.
REQ-023 Backpressure: out_ready low 20 cycles in OUT_HOLD -> out_valid and out_score stable, in_ready low, transfer on first out_ready cycle.
REQ-024 Timeout: TIMEOUT_CYCLES=100, l2_done never sent -> out_valid 100 cycles after l2_start path enters L2_WAIT, out_score=0, out_error=1; l2_done at expiry cycle -> normal completion.
REQ-025 Abort in L1_WAIT -> IDLE next cycle, in_ready high following cycle, late l1_done ignored, frame_count unchanged.
REQ-026 Stray l3_done during L1_WAIT and rst asserted in L2_WAIT -> ignored and full zero reset respectively.
REQ-027 frame_count at 0xFFFF plus one completed frame -> wraps to 0x0000.
